// File: rtl/demorgan_pkg.sv
// Shared types and constants for the De Morgan sweep checker.
// Imported by the evaluator and the sweep top level.
package demorgan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic MODE_NAND = 1'b0;
  localparam logic MODE_NOR  = 1'b1;

endpackage

// File: rtl/demorgan_eval.sv
// Combinational evaluator: both sides of the selected De Morgan law.
// NAND law: ~&x vs |~x.  NOR law: ~|x vs &~x.
module demorgan_eval
  import demorgan_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic         mode,
  output logic         lhs,
  output logic         rhs
);

  always_comb begin
    lhs = ~(&x);
    rhs = |(~x);
    unique case (1'b1)
      (mode == MODE_NOR): begin
        lhs = ~(|x);
        rhs = &(~x);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Self-sequencing De Morgan equivalence sweep with fault injection.
// Walks all 2^N vectors, registers both law sides, counts mismatches.
module demorgan_sweep_checker
  import demorgan_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic         inject,
  input  logic [N-1:0] fault_vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N-1:0] vec,
  output logic         y_lhs,
  output logic         y_rhs,
  output logic         cmp_valid,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_err_vec,
  output logic         first_err_valid
);

  state_t       state;
  state_t       state_nxt;
  logic         mode_q;
  logic         inject_q;
  logic [N-1:0] fault_q;
  logic [N-1:0] vec_prev;
  logic         lhs;
  logic         rhs;
  logic         rhs_f;
  logic         last_vec;
  logic         mismatch;
  logic         accept;

  demorgan_eval #(.N(N)) u_eval (
    .x    (vec),
    .mode (mode_q),
    .lhs  (lhs),
    .rhs  (rhs)
  );

  assign last_vec = &vec;
  assign rhs_f    = rhs ^ (inject_q && (vec == fault_q));
  assign mismatch = cmp_valid && (y_lhs != y_rhs);
  assign accept   = start &&
                    ((state == S_IDLE) || (state == S_DONE));

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_vec) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q          <= 1'b0;
      inject_q        <= 1'b0;
      fault_q         <= '0;
      vec             <= '0;
      vec_prev        <= '0;
      y_lhs           <= 1'b0;
      y_rhs           <= 1'b0;
      cmp_valid       <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else if (accept) begin
      mode_q          <= mode;
      inject_q        <= inject;
      fault_q         <= fault_vec;
      vec             <= '0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      if (state == S_RUN) begin
        y_lhs     <= lhs;
        y_rhs     <= rhs_f;
        cmp_valid <= 1'b1;
        vec_prev  <= vec;
        if (!last_vec) vec <= vec + N'(1);
      end else if (state == S_DRAIN) begin
        cmp_valid <= 1'b0;
      end
      // vec_prev still names the vector behind the pair being compared
      if (mismatch) begin
        err_count <= err_count + (N+1)'(1);
        if (!first_err_valid) begin
          first_err_vec   <= vec_prev;
          first_err_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Scoreboard bench: stimulus pushes expected pairs and results,
// monitors pop and compare as the DUTs present them.
module tb_demorgan_sweep_checker;

  localparam int N  = 4;
  localparam int V  = 1 << N;
  localparam int N2 = 2;
  localparam int V2 = 1 << N2;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic mode;
  logic inject;
  logic [N-1:0] fault_vec;
  logic busy, done, pass;
  logic [N-1:0] vec;
  logic y_lhs, y_rhs, cmp_valid;
  logic [N:0] err_count;
  logic [N-1:0] first_err_vec;
  logic first_err_valid;

  logic start2;
  logic mode2;
  logic inject2;
  logic [N2-1:0] fault_vec2;
  logic busy2, done2, pass2;
  logic [N2-1:0] vec2;
  logic y_lhs2, y_rhs2, cmp_valid2;
  logic [N2:0] err_count2;
  logic [N2-1:0] first_err_vec2;
  logic first_err_valid2;

  demorgan_sweep_checker #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .inject(inject), .fault_vec(fault_vec),
    .busy(busy), .done(done), .pass(pass), .vec(vec),
    .y_lhs(y_lhs), .y_rhs(y_rhs), .cmp_valid(cmp_valid),
    .err_count(err_count), .first_err_vec(first_err_vec),
    .first_err_valid(first_err_valid)
  );

  demorgan_sweep_checker #(.N(N2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2),
    .inject(inject2), .fault_vec(fault_vec2),
    .busy(busy2), .done(done2), .pass(pass2), .vec(vec2),
    .y_lhs(y_lhs2), .y_rhs(y_rhs2), .cmp_valid(cmp_valid2),
    .err_count(err_count2), .first_err_vec(first_err_vec2),
    .first_err_valid(first_err_valid2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int err;
    int fev;
    bit fvalid;
    bit pass;
  } res_t;

  bit [1:0] pairq[$];
  res_t     resq[$];
  int       e0q[$];
  bit [1:0] pairq2[$];
  int       e0q2[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit done_q = 0;
  bit done2_q = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  task automatic bad(input string nm);
    n_chk++;
    $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
  endtask

  // Reference: the law always holds, so both sides are just the
  // truth of "not all ones" (NAND) or "all zeros" (NOR), then the fault.
  task automatic model(input bit m, input bit inj, input int fv);
    int errs;
    int first;
    res_t r;
    bit l, rr;
    errs  = 0;
    first = -1;
    for (int x = 0; x < V; x++) begin
      l  = m ? (x == 0) : (x != V - 1);
      rr = l ^ (inj && (x == fv));
      pairq.push_back({l, rr});
      if (l != rr) begin
        errs++;
        if (first < 0) first = x;
      end
    end
    r.err    = errs;
    r.fev    = (first < 0) ? 0 : first;
    r.fvalid = (first >= 0);
    r.pass   = (errs == 0);
    resq.push_back(r);
  endtask

  task automatic flush();
    pairq.delete();
    resq.delete();
    e0q.delete();
  endtask

  task automatic start_sweep(input bit m, input bit inj,
                             input logic [N-1:0] fv);
    mode      = m;
    inject    = inj;
    fault_vec = fv;
    start     = 1'b1;
    model(m, inj, int'(fv));
    @(posedge clk);
    #1;
    start     = 1'b0;
    mode      = 1'($urandom);
    inject    = 1'($urandom);
    fault_vec = N'($urandom);
    e0q.push_back(cyc);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("vec_after_start", 32'(vec), 32'd0);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      bad("done_timeout");
      flush();
    end
  endtask

  always @(negedge clk) begin
    bit [1:0] p;
    res_t r;
    int e0;
    if (cmp_valid) begin
      if (pairq.size() == 0) bad("unexpected_pair");
      else begin
        p = pairq.pop_front();
        chk("y_lhs", 32'(y_lhs), 32'(p[1]));
        chk("y_rhs", 32'(y_rhs), 32'(p[0]));
      end
    end
    if (done && !done_q) begin
      if (resq.size() == 0) bad("unexpected_done");
      else begin
        r = resq.pop_front();
        chk("err_count", 32'(err_count), 32'(r.err));
        chk("first_err_vec", 32'(first_err_vec), 32'(r.fev));
        chk("first_err_valid", 32'(first_err_valid), 32'(r.fvalid));
        chk("pass", 32'(pass), 32'(r.pass));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      if (e0q.size() != 0) begin
        e0 = e0q.pop_front();
        chk("done_latency", 32'(cyc - e0), 32'(V + 1));
      end
    end
    done_q = done;
  end

  always @(negedge clk) begin
    bit [1:0] p;
    int e0;
    if (cmp_valid2) begin
      if (pairq2.size() == 0) bad("n2_unexpected_pair");
      else begin
        p = pairq2.pop_front();
        chk("n2_y_lhs", 32'(y_lhs2), 32'(p[1]));
        chk("n2_y_rhs", 32'(y_rhs2), 32'(p[0]));
      end
    end
    if (done2 && !done2_q) begin
      chk("n2_pass", 32'(pass2), 32'd1);
      chk("n2_err_count", 32'(err_count2), 32'd0);
      if (e0q2.size() != 0) begin
        e0 = e0q2.pop_front();
        chk("n2_done_latency", 32'(cyc - e0), 32'(V2 + 1));
      end
    end
    done2_q = done2;
  end

  initial begin
    int k;
    rst        = 1'b1;
    start      = 1'b0;
    mode       = 1'b0;
    inject     = 1'b0;
    fault_vec  = '0;
    start2     = 1'b0;
    mode2      = 1'b0;
    inject2    = 1'b0;
    fault_vec2 = '0;
    #1;
    chk("reset_outputs",
        32'({busy, done, pass, vec, y_lhs, y_rhs, cmp_valid,
             err_count, first_err_vec, first_err_valid}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start_sweep(1'b0, 1'b0, 4'h0);
    wait_done();
    start_sweep(1'b0, 1'b1, 4'hA);
    wait_done();
    start_sweep(1'b1, 1'b1, 4'h0);
    wait_done();

    start_sweep(1'b0, 1'b1, 4'h3);
    repeat (5) @(negedge clk);
    start     = 1'b1;
    mode      = 1'b1;
    inject    = 1'b0;
    fault_vec = 4'h9;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    for (int i = 0; i < 6; i++) begin
      start_sweep(1'($urandom), 1'($urandom), N'($urandom));
      wait_done();
      if (i % 2 == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    @(negedge clk);
    start_sweep(1'b0, 1'b1, 4'h9);
    k = 0;
    while (vec != 4'h7 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (vec != 4'h7) bad("vec7_timeout");
    #2;
    rst = 1'b1;
    #1;
    chk("midsweep_reset",
        32'({busy, done, pass, vec, y_lhs, y_rhs, cmp_valid,
             err_count, first_err_vec, first_err_valid}), 32'd0);
    flush();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_sweep(1'b0, 1'b0, 4'h0);
    wait_done();

    @(negedge clk);
    for (int x = 0; x < V2; x++) begin
      pairq2.push_back((x != V2 - 1) ? 2'b11 : 2'b00);
    end
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    e0q2.push_back(cyc);
    k = 0;
    while (!done2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done2) bad("n2_done_timeout");
    @(negedge clk);

    chk("pair_queue_empty", 32'(pairq.size()), 32'd0);
    chk("res_queue_empty", 32'(resq.size()), 32'd0);
    chk("n2_queue_empty", 32'(pairq2.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
